div_issue_ctrl: RTL and testbench
=================================

// Module: div_issue_ctrl
// PURPOSE
//  Sequencer between the EX stage and the radix-2 SRT divider core. Accepts DIV/DIVU/MOD/MODU
//  requests over valid/ready, resolves divide-by-zero, signed overflow and repeat-operand hits
//  without the core, otherwise launches the core and returns the selected quotient or remainder.
//  Handles pipeline flush, including draining a core operation that cannot be aborted.
// PARAMETERS
//  DATA_W    32  operand/result width; the core is fixed at 32, only 32 is legal
//  CACHE_EN  1   1 = hold the last core result and reuse it when operands and signedness match
// PORTS
//  clk            in   1       single clock; all state on rising edge
//  rst            in   1       synchronous, active-high reset
//  req_valid      in   1       request present
//  req_ready      out  1       controller accepts this cycle
//  req_op         in   2       div_pkg::DIV_OP_* (00 DIV, 01 DIVU, 10 MOD, 11 MODU)
//  req_src1       in   DATA_W  dividend
//  req_src2       in   DATA_W  divisor
//  flush          in   1       cancel any accepted, unreturned request
//  resp_valid     out  1       result available
//  resp_ready     in   1       consumer takes the result
//  resp_data      out  DATA_W  quotient (DIV*) or remainder (MOD*)
//  busy           out  1       state != IDLE
//  core_enable    out  1       one-cycle launch pulse to the core
//  core_sign_en   out  1       signed operation, held stable from launch to complete
//  core_op1       out  DATA_W  dividend, held stable from launch to complete
//  core_op2       out  DATA_W  divisor, held stable from launch to complete
//  core_ready     in   1       core idle
//  core_complete  in   1       core_quo/core_rem are valid in this cycle
//  core_quo       in   DATA_W  core quotient
//  core_rem       in   DATA_W  core remainder
// BEHAVIOUR
//  Reset: state IDLE, cache invalid, operand regs 0.
//   Outputs at reset: resp_valid=0, resp_data=0, core_enable=0, core_sign_en=0,
//   core_op1=core_op2=0, busy=0.
//  req_ready = (state==IDLE) & core_ready & ~flush. Handshake = req_valid & req_ready.
//  On handshake, latch op, src1, src2, signed = ~op[0]. Classify, priority high to low:
//   a) src2==0: quo=all-ones, rem=src1.
//   b) signed & src1==0x8000_0000 & src2==all-ones: quo=0x8000_0000, rem=0.
//   c) CACHE_EN & cache valid & {src1,src2,signed}=={tag}: use the cached quo and rem.
//   Cases a/b/c go to DONE on the next edge.
//   d) otherwise go to ISSUE.
//  States:
//   IDLE  -> DONE  on handshake with a/b/c.
//   IDLE  -> ISSUE on handshake with d.
//   ISSUE: core_enable=1 for exactly one cycle. Go to WAIT, or to DRAIN if flush.
//   WAIT:  on core_complete, capture core_quo/core_rem, fill the cache, go to DONE.
//          If flush is also high that cycle, still fill the cache but go to IDLE (no response).
//          On flush without core_complete, go to DRAIN.
//   DRAIN: wait for core_complete, fill the cache, go to IDLE. Flush is ignored.
//   DONE:  resp_valid=1. Go to IDLE on resp_ready or on flush.
//          Flush wins: the result is dropped.
//  resp_data is selected by op[1] and holds stable while resp_valid & ~resp_ready.
//  Latency, handshake to resp_valid: 1 cycle for a/b/c; 3 cycles + core time for d
//   (ISSUE, core SAMP, DIV iterations, core_complete cycle).
//  No back-to-back issue: IDLE is always revisited between requests.
//  Cache tag is {src1, src2, signed}; op is not part of the tag, so MOD after DIV hits.
//   Cache is invalidated only by rst.
//  Any core_complete seen outside WAIT/DRAIN is ignored.
//  rst mid-operation returns to IDLE. The core is reset from the same rst (rstn = ~rst at top);
//   req_ready gates on core_ready regardless.
// STRUCTURE
//  div_pkg: DIV_OP_* encodings, state localparams (one-hot, 5 states), DIV_W=32.
//  One sub-module, div_special_detect (combinational):
//   inputs src1, src2, signed; outputs is_zero, is_ovf, spec_quo, spec_rem.
//  Controller FSM, operand/result registers and cache live in div_issue_ctrl.
// TESTING
//  1 DIV  -7 / 2     -> core launched once; resp_data=0xFFFF_FFFD. Then MOD same operands ->
//                       hit in 1 cycle, resp_data=0xFFFF_FFFF, no core_enable.
//  2 DIVU 5 / 0      -> resp_data=0xFFFF_FFFF 1 cycle after handshake.
//    MODU 5 / 0      -> resp_data=5. No core_enable in either case.
//  3 DIV 0x8000_0000 / 0xFFFF_FFFF -> resp_data=0x8000_0000; MOD same -> 0. No core_enable.
//  4 DIVU 100 / 7, flush in the 2nd WAIT cycle -> no resp_valid; req_ready=0 until
//    core_complete. The next request DIVU 100 / 7 hits the cache and returns 14.
//  5 DIV 1000 / 3 with resp_ready held low 5 cycles -> resp_valid and resp_data=333 held stable;
//    req_ready=0 throughout.
//  6 rst asserted in WAIT -> next cycle all outputs at reset values; first request after core_ready
//    is handled correctly; cache miss.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg
//  Shared definitions for the divider issue controller.
//  - DIV_W       : datapath width of the SRT divider core (fixed at 32)
//  - DIV_OP_*    : request opcode encodings (bit 1 = remainder, bit 0 = unsigned)
//  - ST_*        : one-hot controller state encodings (5 states)
//  - op_is_signed: signedness of an opcode
package div_pkg;

  localparam int DIV_W = 32;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_MOD  = 2'b10;
  localparam logic [1:0] DIV_OP_MODU = 2'b11;

  localparam logic [4:0] ST_IDLE  = 5'b00001;
  localparam logic [4:0] ST_ISSUE = 5'b00010;
  localparam logic [4:0] ST_WAIT  = 5'b00100;
  localparam logic [4:0] ST_DRAIN = 5'b01000;
  localparam logic [4:0] ST_DONE  = 5'b10000;

  // Bit 0 of the opcode selects unsigned, so signed is its complement.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/div_special_detect.sv
// div_special_detect
//  Combinational detection of the divide cases that never need the core.
//  Ports:
//   src1      in  DATA_W  dividend
//   src2      in  DATA_W  divisor
//   is_signed in  1       signed operation
//   is_zero   out 1       divisor is zero
//   is_ovf    out 1       signed most-negative / -1 overflow
//   spec_quo  out DATA_W  quotient for the special case (valid if is_zero|is_ovf)
//   spec_rem  out DATA_W  remainder for the special case (valid if is_zero|is_ovf)
module div_special_detect
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_W
) (
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              is_signed,
  output logic              is_zero,
  output logic              is_ovf,
  output logic [DATA_W-1:0] spec_quo,
  output logic [DATA_W-1:0] spec_rem
);

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  // Divide-by-zero takes priority: an all-ones divisor can never also be zero,
  // so the two flags are exclusive anyway, but the result mux favours is_zero.
  always_comb begin
    is_zero  = (src2 == '0);
    is_ovf   = is_signed && (src1 == MOST_NEG) && (src2 == '1);
    spec_quo = MOST_NEG;
    spec_rem = '0;
    if (is_zero) begin
      spec_quo = '1;
      spec_rem = src1;
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl
//  Sequencer between the EX stage and the radix-2 SRT divider core. Special
//  cases (divide-by-zero, signed overflow) and repeat-operand cache hits are
//  answered locally; everything else is launched on the core. A flush while
//  the core is busy drains the core before accepting new work.
//  Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_op, req_src1, req_src2    opcode, dividend, divisor
//   flush                         cancel the accepted, unreturned request
//   resp_valid/resp_ready         response handshake
//   resp_data                     quotient (DIV*) or remainder (MOD*)
//   busy                          controller not idle
//   core_enable                   one-cycle launch pulse to the core
//   core_sign_en, core_op1/op2    operands to the core, stable during a run
//   core_ready, core_complete     core idle / result valid this cycle
//   core_quo, core_rem            core results
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int DATA_W   = DIV_W,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_src1,
  input  logic [DATA_W-1:0] req_src2,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              busy,
  output logic              core_enable,
  output logic              core_sign_en,
  output logic [DATA_W-1:0] core_op1,
  output logic [DATA_W-1:0] core_op2,
  input  logic              core_ready,
  input  logic              core_complete,
  input  logic [DATA_W-1:0] core_quo,
  input  logic [DATA_W-1:0] core_rem
);

  logic [4:0]        state;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] src1_q;
  logic [DATA_W-1:0] src2_q;
  logic              sign_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] rem_q;

  logic              cache_valid;
  logic [DATA_W-1:0] cache_src1;
  logic [DATA_W-1:0] cache_src2;
  logic              cache_sign;
  logic [DATA_W-1:0] cache_quo;
  logic [DATA_W-1:0] cache_rem;

  logic              req_sign;
  logic              handshake;
  logic              cache_hit;
  logic              cache_fill;
  logic              is_zero;
  logic              is_ovf;
  logic [DATA_W-1:0] spec_quo;
  logic [DATA_W-1:0] spec_rem;

  assign req_sign = op_is_signed(req_op);

  div_special_detect #(.DATA_W(DATA_W)) u_special (
    .src1      (req_src1),
    .src2      (req_src2),
    .is_signed (req_sign),
    .is_zero   (is_zero),
    .is_ovf    (is_ovf),
    .spec_quo  (spec_quo),
    .spec_rem  (spec_rem)
  );

  // Requests are only taken from IDLE with the core free; the core_ready gate
  // matters after a reset, when the core may still be coming out of reset.
  always_comb begin
    req_ready = (state == ST_IDLE) && core_ready && !flush;
    handshake = req_valid && req_ready;
    cache_hit = CACHE_EN && cache_valid && (req_src1 == cache_src1) &&
                (req_src2 == cache_src2) && (req_sign == cache_sign);
    cache_fill = core_complete && ((state == ST_WAIT) || (state == ST_DRAIN));
  end

  // Operand and result registers are only written at acceptance or at core
  // completion, which keeps core operands and resp_data stable in between.
  always_comb begin
    busy         = (state != ST_IDLE);
    core_enable  = (state == ST_ISSUE);
    resp_valid   = (state == ST_DONE);
    core_sign_en = sign_q;
    core_op1     = src1_q;
    core_op2     = src2_q;
    resp_data    = op_q[1] ? rem_q : quo_q;
  end

  // Controller FSM. Special cases and cache hits jump straight to DONE; misses
  // go through ISSUE/WAIT. A flush after launch cannot abort the core, so the
  // controller drains it (DRAIN) and the result still refreshes the cache.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      op_q   <= '0;
      src1_q <= '0;
      src2_q <= '0;
      sign_q <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (handshake) begin
            op_q   <= req_op;
            src1_q <= req_src1;
            src2_q <= req_src2;
            sign_q <= req_sign;
            if (is_zero || is_ovf) begin
              quo_q <= spec_quo;
              rem_q <= spec_rem;
              state <= ST_DONE;
            end else if (cache_hit) begin
              quo_q <= cache_quo;
              rem_q <= cache_rem;
              state <= ST_DONE;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          state <= flush ? ST_DRAIN : ST_WAIT;
        end
        ST_WAIT: begin
          if (core_complete) begin
            quo_q <= core_quo;
            rem_q <= core_rem;
            state <= flush ? ST_IDLE : ST_DONE;
          end else if (flush) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (core_complete) begin
            state <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (flush || resp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Result cache: refreshed by every core result, flushed or not, and only
  // invalidated by reset. The tag deliberately excludes the opcode so that a
  // remainder request following the matching divide hits.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid <= 1'b0;
      cache_src1  <= '0;
      cache_src2  <= '0;
      cache_sign  <= 1'b0;
      cache_quo   <= '0;
      cache_rem   <= '0;
    end else if (cache_fill) begin
      cache_valid <= CACHE_EN;
      cache_src1  <= src1_q;
      cache_src2  <= src2_q;
      cache_sign  <= sign_q;
      cache_quo   <= core_quo;
      cache_rem   <= core_rem;
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl
//  Scoreboard bench for div_issue_ctrl with a behavioural divider core.
module tb_div_issue_ctrl;
  import div_pkg::*;

  localparam int CORE_LAT = 10;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        busy;
  logic        core_enable;
  logic        core_sign_en;
  logic [31:0] core_op1;
  logic [31:0] core_op2;
  logic        core_ready;
  logic        core_complete;
  logic [31:0] core_quo;
  logic [31:0] core_rem;

  int          n_checks;
  int          n_fail;
  int          en_count;
  logic [31:0] exp_q[$];

  logic [5:0]  core_cnt;
  logic [31:0] core_q_r;
  logic [31:0] core_r_r;

  div_issue_ctrl #(.DATA_W(32), .CACHE_EN(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_src1      (req_src1),
    .req_src2      (req_src2),
    .flush         (flush),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .busy          (busy),
    .core_enable   (core_enable),
    .core_sign_en  (core_sign_en),
    .core_op1      (core_op1),
    .core_op2      (core_op2),
    .core_ready    (core_ready),
    .core_complete (core_complete),
    .core_quo      (core_quo),
    .core_rem      (core_rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural divider core: samples operands on the launch pulse, then
  // raises core_complete for one cycle after a fixed latency.
  always @(posedge clk) begin
    if (rst) begin
      core_cnt <= '0;
    end else if (core_enable) begin
      core_cnt <= 6'(CORE_LAT);
      if (core_sign_en) begin
        core_q_r <= $signed(core_op1) / $signed(core_op2);
        core_r_r <= $signed(core_op1) % $signed(core_op2);
      end else begin
        core_q_r <= core_op1 / core_op2;
        core_r_r <= core_op1 % core_op2;
      end
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 6'd1;
    end
  end

  assign core_ready    = (core_cnt == 0);
  assign core_complete = (core_cnt == 1);
  assign core_quo      = core_q_r;
  assign core_rem      = core_r_r;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Launch pulses are counted away from the active edge.
  always @(negedge clk) begin
    if (!rst && core_enable) en_count++;
  end

  // Monitor: every consumed response is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected resp", resp_data, 32'hDEAD_BEEF ^ resp_data ^ 32'h1);
      end else begin
        checkOutput("resp_data", resp_data, exp_q.pop_front());
      end
    end
  end

  task automatic issueRaw(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int k;
    k = 0;
    while (!req_ready && k < 200) begin
      tick;
      k++;
    end
    checkOutput("req_ready wait", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    tick;
    req_valid = 1'b0;
  endtask

  task automatic applyStimulus(input string name, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expd, input bit hit);
    int k;
    int en0;
    en0 = en_count;
    exp_q.push_back(expd);
    issueRaw(op, a, b);
    checkOutput({name, " first-cycle resp_valid"}, {31'b0, resp_valid}, hit ? 32'd1 : 32'd0);
    k = 0;
    while (!resp_valid && k < 200) begin
      tick;
      k++;
    end
    checkOutput({name, " resp_valid"}, {31'b0, resp_valid}, 32'd1);
    checkOutput({name, " launches"}, 32'(en_count - en0), hit ? 32'd0 : 32'd1);
  endtask

  task automatic finishResp;
    int k;
    k = 0;
    while (resp_valid && k < 50) begin
      tick;
      k++;
    end
    checkOutput("resp retired", {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    int en0;
    n_checks   = 0;
    n_fail     = 0;
    en_count   = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_src1   = '0;
    req_src2   = '0;
    flush      = 1'b0;
    resp_ready = 1'b1;
    tick;
    tick;
    tick;

    checkOutput("rst resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst resp_data", resp_data, 32'd0);
    checkOutput("rst core_enable", {31'b0, core_enable}, 32'd0);
    checkOutput("rst core_sign_en", {31'b0, core_sign_en}, 32'd0);
    checkOutput("rst core_op1", core_op1, 32'd0);
    checkOutput("rst core_op2", core_op2, 32'd0);
    checkOutput("rst busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    tick;
    checkOutput("idle req_ready", {31'b0, req_ready}, 32'd1);
    flush = 1'b1;
    #1;
    checkOutput("flush blocks req_ready", {31'b0, req_ready}, 32'd0);
    flush = 1'b0;
    tick;

    $display("[TB] signed divide, then remainder from cache");
    applyStimulus("DIV -7/2", DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    finishResp;
    applyStimulus("MOD -7/2", DIV_OP_MOD, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
    finishResp;
    applyStimulus("DIVU 0xFFFFFFF9/2", DIV_OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 1'b0);
    finishResp;

    $display("[TB] divide by zero");
    applyStimulus("DIVU 5/0", DIV_OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    finishResp;
    applyStimulus("MODU 5/0", DIV_OP_MODU, 32'd5, 32'd0, 32'd5, 1'b1);
    finishResp;
    applyStimulus("DIV 5/0", DIV_OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    finishResp;

    $display("[TB] signed overflow and its unsigned twin");
    applyStimulus("DIV ovf", DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    finishResp;
    applyStimulus("MOD ovf", DIV_OP_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
    finishResp;
    applyStimulus("DIVU 0x80000000/-1", DIV_OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
    finishResp;
    applyStimulus("MODU 0x80000000/-1", DIV_OP_MODU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    finishResp;

    $display("[TB] flush during WAIT drains the core");
    en0 = en_count;
    issueRaw(DIV_OP_DIVU, 32'd100, 32'd7);
    tick;
    tick;
    flush = 1'b1;
    #1;
    checkOutput("flush in WAIT req_ready", {31'b0, req_ready}, 32'd0);
    tick;
    flush = 1'b0;
    checkOutput("drain req_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("drain busy", {31'b0, busy}, 32'd1);
    k = 0;
    while (!req_ready && k < 200) begin
      if (resp_valid) checkOutput("drain resp_valid", {31'b0, resp_valid}, 32'd0);
      tick;
      k++;
    end
    checkOutput("drain released", {31'b0, req_ready}, 32'd1);
    checkOutput("drain launches", 32'(en_count - en0), 32'd1);
    applyStimulus("DIVU 100/7 after drain", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
    finishResp;

    $display("[TB] flush in DONE drops the response");
    resp_ready = 1'b0;
    issueRaw(DIV_OP_DIVU, 32'd5, 32'd0);
    checkOutput("done before flush", {31'b0, resp_valid}, 32'd1);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    checkOutput("done after flush", {31'b0, resp_valid}, 32'd0);
    checkOutput("busy after flush", {31'b0, busy}, 32'd0);

    $display("[TB] back-pressured response");
    applyStimulus("DIV 1000/3", DIV_OP_DIV, 32'd1000, 32'd3, 32'd333, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("held resp_valid", {31'b0, resp_valid}, 32'd1);
      checkOutput("held resp_data", resp_data, 32'd333);
      checkOutput("held req_ready", {31'b0, req_ready}, 32'd0);
      tick;
    end
    resp_ready = 1'b1;
    finishResp;
    applyStimulus("MOD 1000/3", DIV_OP_MOD, 32'd1000, 32'd3, 32'd1, 1'b1);
    finishResp;

    $display("[TB] reset in WAIT");
    issueRaw(DIV_OP_DIV, 32'd1000, 32'd7);
    tick;
    tick;
    rst = 1'b1;
    tick;
    checkOutput("midrst resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("midrst resp_data", resp_data, 32'd0);
    checkOutput("midrst core_enable", {31'b0, core_enable}, 32'd0);
    checkOutput("midrst core_sign_en", {31'b0, core_sign_en}, 32'd0);
    checkOutput("midrst core_op1", core_op1, 32'd0);
    checkOutput("midrst core_op2", core_op2, 32'd0);
    checkOutput("midrst busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    tick;
    applyStimulus("DIV 1000/3 after rst", DIV_OP_DIV, 32'd1000, 32'd3, 32'd333, 1'b0);
    finishResp;

    tick;
    checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
